sub_word_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 56 +++++
 rtl/sbox_lane.sv | 12 +
 rtl/sub_word_seq.sv | 126 ++++++++++++
 tb/tb_sub_word_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type, forward/inverse S-box tables, RotWord
// helper and the sequencer state encoding.
package aes_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sws_state_t;

    localparam byte_t SBOX_ROM [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX_ROM [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // RotWord: cyclic left rotation of a word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane: forward or inverse lookup selected by inv.
module sbox_lane
    import aes_pkg::*;
(
    input  byte_t din,
    input  logic  inv,
    output byte_t dout
);

    assign dout = inv ? INV_SBOX_ROM[din] : SBOX_ROM[din];

endmodule

// File: rtl/sub_word_seq.sv
// Time-multiplexed SubWord/SubBytes engine: substitutes SBOX_LANES bytes of a
// NUM_WORDS x 32-bit block per cycle, with optional per-word RotWord on capture.
module sub_word_seq
    import aes_pkg::*;
#(
    parameter int NUM_WORDS  = 4,
    parameter int SBOX_LANES = 4
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [32*NUM_WORDS-1:0] in_data,
    input  logic                    in_inv,
    input  logic                    in_rot,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [32*NUM_WORDS-1:0] out_data,
    output logic                    busy
);

    localparam int DATA_W = 32 * NUM_WORDS;
    localparam int NBYTES = 4 * NUM_WORDS;
    localparam int BEATS  = NBYTES / SBOX_LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Lane count must tile the block exactly, otherwise beats would straddle bytes.
    generate
        if (SBOX_LANES < 1 || (NBYTES % SBOX_LANES) != 0) begin : g_bad_lanes
            $error("sub_word_seq: SBOX_LANES must divide 4*NUM_WORDS");
        end
    endgenerate

    sws_state_t         state_reg, state_next;
    logic [DATA_W-1:0]  work_reg;
    logic [DATA_W-1:0]  work_next;
    logic [DATA_W-1:0]  cap_data;
    logic [CNT_W-1:0]   cnt_reg;
    logic               inv_reg;
    logic               out_valid_reg;
    logic [DATA_W-1:0]  out_data_reg;
    logic               accept;
    logic               last_beat;
    int                 chunk_base;
    byte_t              lane_in  [SBOX_LANES];
    byte_t              lane_out [SBOX_LANES];

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign busy       = (state_reg == BUSY);
    assign last_beat  = (cnt_reg == CNT_W'(BEATS - 1));
    assign chunk_base = int'(cnt_reg) * SBOX_LANES;

    // RotWord is folded into capture so the beats only ever substitute.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_cap
            assign cap_data[DATA_W-1-32*gi -: 32] = in_rot ? rot_word(in_data[DATA_W-1-32*gi -: 32])
                                                           : in_data[DATA_W-1-32*gi -: 32];
        end
    endgenerate

    // Each lane picks its byte of the current chunk; byte 0 is the block MSB.
    generate
        for (genvar gi = 0; gi < SBOX_LANES; gi++) begin : g_lane
            assign lane_in[gi] = byte_t'(work_reg >> (DATA_W - 8 - 8 * (chunk_base + gi)));
            sbox_lane u_lane (
                .din  (lane_in[gi]),
                .inv  (inv_reg),
                .dout (lane_out[gi])
            );
        end
    endgenerate

    // Write the substituted chunk back in place; other bytes pass through.
    always_comb begin
        work_next = work_reg;
        for (int i = 0; i < SBOX_LANES; i++) begin
            work_next = (work_next & ~({{(DATA_W-8){1'b0}}, 8'hFF} << (DATA_W - 8 - 8 * (chunk_base + i))))
                      | ({{(DATA_W-8){1'b0}}, lane_out[i]} << (DATA_W - 8 - 8 * (chunk_base + i)));
        end
    end

    // Handshake and next-state logic.
    always_comb begin
        state_next = state_reg;
        in_ready   = (state_reg == IDLE) || (state_reg == DONE && out_ready);
        accept     = in_valid && in_ready;
        case (state_reg)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (last_beat) state_next = DONE;
            DONE: if (out_ready) state_next = accept ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, working register, beat counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            work_reg      <= '0;
            cnt_reg       <= '0;
            inv_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DONE && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (accept) begin
                work_reg <= cap_data;
                inv_reg  <= in_inv;
                cnt_reg  <= '0;
            end else if (state_reg == BUSY) begin
                work_reg <= work_next;
                cnt_reg  <= last_beat ? '0 : cnt_reg + 1'b1;
                if (last_beat) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= work_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_sub_word_seq.sv
// Directed bench for sub_word_seq: default (4,4) instance plus a (1,1) instance
// for the single-word RotWord key-expansion case.
module tb_sub_word_seq;

    localparam logic [127:0] PLAIN_A = 128'h00010253_FF000000_00000000_00000000;
    localparam logic [127:0] SUB_A   = 128'h637C77ED_16636363_63636363_63636363;
    localparam logic [127:0] ROT_A   = 128'h7C77ED63_63636316_63636363_63636363;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         in_valid = 1'b0, in_inv = 1'b0, in_rot = 1'b0, out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;

    logic         in_valid1 = 1'b0, in_inv1 = 1'b0, in_rot1 = 1'b0, out_ready1 = 1'b0;
    logic [31:0]  in_data1 = '0;
    logic         in_ready1, out_valid1, busy1;
    logic [31:0]  out_data1;

    int checks = 0;
    int errors = 0;
    logic [127:0] held;

    always #5 clk = ~clk;

    sub_word_seq #(.NUM_WORDS(4), .SBOX_LANES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_inv(in_inv), .in_rot(in_rot),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    sub_word_seq #(.NUM_WORDS(1), .SBOX_LANES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .in_inv(in_inv1), .in_rot(in_rot1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        // Reset
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_out_data", out_data, '0);
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("rst1_out_data", 128'(out_data1), '0);
        check("rst1_in_ready", 128'(in_ready1), 128'(1'b1));

        // Forward substitution, latency 4
        in_valid = 1'b1; in_data = PLAIN_A; in_inv = 1'b0; in_rot = 1'b0;
        step();                                   // E0
        in_valid = 1'b0; in_data = '1; in_inv = 1'b1; in_rot = 1'b1;
        check("fwd_busy_e0", 128'(busy), 128'(1'b1));
        check("fwd_in_ready_busy", 128'(in_ready), 128'(1'b0));
        step(); step(); step();                   // E1..E3
        check("fwd_no_early_valid", 128'(out_valid), 128'(1'b0));
        step();                                   // E4
        check("fwd_out_valid", 128'(out_valid), 128'(1'b1));
        check("fwd_out_data", out_data, SUB_A);
        check("fwd_busy_done", 128'(busy), 128'(1'b0));

        // Backpressure: new request waits, result holds
        in_valid = 1'b1; in_data = SUB_A; in_inv = 1'b1; in_rot = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_in_ready", 128'(in_ready), 128'(1'b0));
            step();
            check("bp_out_valid", 128'(out_valid), 128'(1'b1));
            check("bp_out_data", out_data, SUB_A);
        end

        // Back-to-back: retire and accept on the same edge, inverse op
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 128'(in_ready), 128'(1'b1));
        step();
        in_valid = 1'b0;
        check("b2b_retired", 128'(out_valid), 128'(1'b0));
        check("b2b_busy", 128'(busy), 128'(1'b1));
        check("b2b_in_ready_busy", 128'(in_ready), 128'(1'b0));
        step(); step(); step();
        check("inv_no_early_valid", 128'(out_valid), 128'(1'b0));
        step();
        check("inv_out_valid", 128'(out_valid), 128'(1'b1));
        check("inv_out_data", out_data, PLAIN_A);
        step();                                   // retires, nothing pending
        check("inv_retired_once", 128'(out_valid), 128'(1'b0));
        check("idle_in_ready", 128'(in_ready), 128'(1'b1));
        check("idle_data_kept", out_data, PLAIN_A);
        step();
        check("no_duplicate", 128'(out_valid), 128'(1'b0));

        // Reset in the middle of an operation
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = PLAIN_A; in_inv = 1'b0; in_rot = 1'b0;
        step();                                   // E0
        in_valid = 1'b0;
        step(); step();                           // E1, E2
        rst = 1'b1;
        in_valid = 1'b1;                          // ignored while in reset
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("mid_rst_out_data", out_data, '0);
        check("mid_rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("mid_rst_busy", 128'(busy), 128'(1'b0));
        for (int i = 0; i < 5; i++) begin
            step();
            check("mid_rst_no_valid", 128'(out_valid), 128'(1'b0));
        end

        // Next op after reset, with RotWord on every word
        in_valid = 1'b1; in_data = PLAIN_A; in_inv = 1'b0; in_rot = 1'b1;
        step();
        in_valid = 1'b0; in_rot = 1'b0;
        step(); step(); step(); step();
        check("rot_out_valid", 128'(out_valid), 128'(1'b1));
        check("rot_out_data", out_data, ROT_A);
        held = out_data;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("rot_retired", 128'(out_valid), 128'(1'b0));
        check("rot_data_kept", out_data, held);

        // Single word, single lane, RotWord (key expansion w[3])
        in_valid1 = 1'b1; in_data1 = 32'h09CF4F3C; in_inv1 = 1'b0; in_rot1 = 1'b1;
        step();                                   // E0
        in_valid1 = 1'b0; in_data1 = 32'hFFFFFFFF; in_rot1 = 1'b0; in_inv1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("kx_busy", 128'(busy1), 128'(1'b1));
            check("kx_no_early_valid", 128'(out_valid1), 128'(1'b0));
            step();
        end
        check("kx_out_valid", 128'(out_valid1), 128'(1'b1));
        check("kx_out_data", 128'(out_data1), 128'(32'h8A84EB01));
        check("kx_busy_done", 128'(busy1), 128'(1'b0));
        out_ready1 = 1'b1;
        step();
        check("kx_retired", 128'(out_valid1), 128'(1'b0));
        check("kx_in_ready", 128'(in_ready1), 128'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
